// File: rtl/sekwenser_rozruchu.sv
// Engine start-sequence controller: primes ignition, cranks with a time limit,
// confirms run from RPM, retries with cooldown and latches a fault after the last attempt.
module sekwenser_rozruchu #(
   parameter int unsigned MAX_PROB        = 3,
   parameter int unsigned CZAS_ZAPLONU_S  = 1,
   parameter int unsigned CZAS_ROZRUCHU_S = 5,
   parameter int unsigned CZAS_PRZERWY_S  = 10,
   parameter int unsigned PROG_OBROTOW    = 400,
   parameter int unsigned STAB_CYKLI      = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] taktowanie,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] obroty,
   output logic        rozruch,
   output logic        zaplon,
   output logic        silnik_pracuje,
   output logic        blad,
   output logic [3:0]  proba,
   output logic [2:0]  stan
);

   localparam int unsigned MAX_S_A = (CZAS_ZAPLONU_S > CZAS_ROZRUCHU_S) ? CZAS_ZAPLONU_S : CZAS_ROZRUCHU_S;
   localparam int unsigned MAX_S   = (MAX_S_A > CZAS_PRZERWY_S) ? MAX_S_A : CZAS_PRZERWY_S;
   localparam int unsigned SEK_W   = ($clog2(MAX_S + 1) < 1) ? 1 : $clog2(MAX_S + 1);
   localparam int unsigned STAB_W  = ($clog2(STAB_CYKLI + 1) < 1) ? 1 : $clog2(STAB_CYKLI + 1);
   localparam int unsigned PRESC_W = 32;

   typedef enum logic [2:0] {
      SPOCZYNEK = 3'd0,
      ZAPLON    = 3'd1,
      ROZRUCH   = 3'd2,
      PRZERWA   = 3'd3,
      PRACA     = 3'd4,
      BLAD      = 3'd5
   } stan_t;

   stan_t               stan_q;
   stan_t               stan_next;
   logic [3:0]          proba_q;
   logic [3:0]          proba_next;
   logic [PRESC_W-1:0]  presc_q;
   logic [SEK_W-1:0]    sek_q;
   logic [STAB_W-1:0]   stab_q;
   logic                start_d;
   logic                uzbrojony;

   logic                start_edge_c;
   logic                tick_c;
   logic                zmiana_c;
   logic                stab_hit_c;
   logic                stab_done_c;
   logic                zaplon_koniec_c;
   logic                rozruch_koniec_c;
   logic                przerwa_koniec_c;

   // A start held high since reset must first be seen low before an edge counts.
   assign start_edge_c = start & ~start_d & uzbrojony;

   assign tick_c = (taktowanie != 32'd0) && (presc_q >= (taktowanie - 32'd1));

   assign zaplon_koniec_c  = tick_c && ((32'(sek_q) + 32'd1) >= CZAS_ZAPLONU_S);
   assign rozruch_koniec_c = tick_c && ((32'(sek_q) + 32'd1) >= CZAS_ROZRUCHU_S);
   assign przerwa_koniec_c = tick_c && ((32'(sek_q) + 32'd1) >= CZAS_PRZERWY_S);

   // One counter serves run confirmation while cranking and stall detection while running.
   always_comb begin
      stab_hit_c = 1'b0;
      if (stan_q == ROZRUCH) begin
         stab_hit_c = (obroty >= 16'(PROG_OBROTOW));
      end else if (stan_q == PRACA) begin
         stab_hit_c = (obroty == 16'd0);
      end
   end

   assign stab_done_c = stab_hit_c && ((32'(stab_q) + 32'd1) >= STAB_CYKLI);
   assign zmiana_c    = (stan_next != stan_q);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stan_q  <= SPOCZYNEK;
         proba_q <= 4'd0;
      end else begin
         stan_q  <= stan_next;
         proba_q <= proba_next;
      end
   end

   // Next-state logic; stop overrides everything.
   always_comb begin
      stan_next  = stan_q;
      proba_next = proba_q;
      if (stop) begin
         stan_next  = SPOCZYNEK;
         proba_next = 4'd0;
      end else begin
         unique case (stan_q)
            SPOCZYNEK: begin
               proba_next = 4'd0;
               if (start_edge_c) begin
                  stan_next  = ZAPLON;
                  proba_next = 4'd1;
               end
            end
            ZAPLON: begin
               if (zaplon_koniec_c) begin
                  stan_next = ROZRUCH;
               end
            end
            ROZRUCH: begin
               if (stab_done_c) begin
                  stan_next = PRACA;
               end else if (rozruch_koniec_c) begin
                  stan_next = (proba_q >= 4'(MAX_PROB)) ? BLAD : PRZERWA;
               end
            end
            PRZERWA: begin
               if (przerwa_koniec_c) begin
                  stan_next  = ZAPLON;
                  proba_next = (proba_q != 4'hF) ? proba_q + 4'd1 : proba_q;
               end
            end
            PRACA: begin
               if (stab_done_c) begin
                  stan_next  = SPOCZYNEK;
                  proba_next = 4'd0;
               end
            end
            BLAD: begin
               stan_next = BLAD;
            end
            default: begin
               stan_next  = SPOCZYNEK;
               proba_next = 4'd0;
            end
         endcase
      end
   end

   // Prescaler and seconds counter, restarted on every state entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         sek_q   <= '0;
      end else if (zmiana_c) begin
         presc_q <= '0;
         sek_q   <= '0;
      end else if (tick_c) begin
         presc_q <= '0;
         if (sek_q != {SEK_W{1'b1}}) begin
            sek_q <= sek_q + SEK_W'(1);
         end
      end else if (taktowanie != 32'd0) begin
         presc_q <= presc_q + PRESC_W'(1);
      end
   end

   // Consecutive-cycle counter for stability / stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_q <= '0;
      end else if (zmiana_c || !stab_hit_c) begin
         stab_q <= '0;
      end else if (stab_q != {STAB_W{1'b1}}) begin
         stab_q <= stab_q + STAB_W'(1);
      end
   end

   // Start edge detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_d   <= 1'b0;
         uzbrojony <= 1'b0;
      end else begin
         start_d   <= start;
         uzbrojony <= uzbrojony | ~start;
      end
   end

   // Outputs decoded from the next state so they move on the same edge as stan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rozruch        <= 1'b0;
         zaplon         <= 1'b0;
         silnik_pracuje <= 1'b0;
         blad           <= 1'b0;
         proba          <= 4'd0;
      end else begin
         rozruch        <= (stan_next == ROZRUCH);
         zaplon         <= (stan_next == ZAPLON) || (stan_next == ROZRUCH) || (stan_next == PRACA);
         silnik_pracuje <= (stan_next == PRACA);
         blad           <= (stan_next == BLAD);
         proba          <= proba_next;
      end
   end

   assign stan = stan_q;

endmodule

// File: tb/tb_sekwenser_rozruchu.sv
// Directed bench for sekwenser_rozruchu with hand-computed cycle counts.
`timescale 1ns/1ps
module tb_sekwenser_rozruchu;

   logic        clk;
   logic        rst;
   logic [31:0] taktowanie;
   logic        start;
   logic        stop;
   logic [15:0] obroty;
   logic        rozruch;
   logic        zaplon;
   logic        silnik_pracuje;
   logic        blad;
   logic [3:0]  proba;
   logic [2:0]  stan;

   int checks   = 0;
   int failures = 0;

   sekwenser_rozruchu #(
      .MAX_PROB       (3),
      .CZAS_ZAPLONU_S (1),
      .CZAS_ROZRUCHU_S(3),
      .CZAS_PRZERWY_S (2),
      .PROG_OBROTOW   (400),
      .STAB_CYKLI     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .taktowanie    (taktowanie),
      .start         (start),
      .stop          (stop),
      .obroty        (obroty),
      .rozruch       (rozruch),
      .zaplon        (zaplon),
      .silnik_pracuje(silnik_pracuje),
      .blad          (blad),
      .proba         (proba),
      .stan          (stan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic sprawdz(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic krok();
      @(posedge clk);
      #1;
   endtask

   task automatic kroki(input int n);
      for (int i = 0; i < n; i++) krok();
   endtask

   task automatic impuls_start();
      start = 1'b1;
      krok();
      start = 1'b0;
   endtask

   // Cycles spent in the given state, bounded so a stuck DUT still terminates.
   task automatic licz_stan(input logic [2:0] kod, output int n);
      n = 0;
      while (stan == kod && n < 300) begin
         krok();
         n++;
      end
   endtask

   initial begin
      int n;
      int h;
      rst        = 1'b1;
      taktowanie = 32'd10;
      start      = 1'b0;
      stop       = 1'b0;
      obroty     = 16'd0;
      kroki(2);
      sprawdz("reset_stan", 32'(stan), 32'd0);
      sprawdz("reset_outs", {26'd0, rozruch, zaplon, silnik_pracuje, blad, proba}, 32'd0);
      rst = 1'b0;
      kroki(2);

      // Test 1: confirm run after 15 low cycles and 4 stable ones.
      impuls_start();
      sprawdz("t1_zaplon_stan", 32'(stan), 32'd1);
      sprawdz("t1_zaplon_proba", 32'(proba), 32'd1);
      sprawdz("t1_zaplon_out", {30'd0, zaplon, rozruch}, 32'd2);
      licz_stan(3'd1, n);
      sprawdz("t1_zaplon_len", n, 10);
      h = 0;
      for (int k = 0; k < 15; k++) begin
         if (rozruch) h++;
         krok();
      end
      obroty = 16'd500;
      while (rozruch && h < 100) begin
         h++;
         krok();
      end
      sprawdz("t1_rozruch_len", h, 19);
      sprawdz("t1_stan", 32'(stan), 32'd4);
      sprawdz("t1_outs", {28'd0, silnik_pracuje, zaplon, rozruch, blad}, 32'b1100);
      sprawdz("t1_proba", 32'(proba), 32'd1);

      // Test 5: a 3-cycle dip keeps running, 4 zeros is a stall.
      obroty = 16'd0;
      kroki(3);
      sprawdz("t5_dip3", 32'(stan), 32'd4);
      obroty = 16'd100;
      krok();
      obroty = 16'd0;
      kroki(3);
      sprawdz("t5_zero3", 32'(stan), 32'd4);
      krok();
      sprawdz("t5_stall_stan", 32'(stan), 32'd0);
      sprawdz("t5_stall_outs", {27'd0, zaplon, silnik_pracuje, proba}, 32'd0);

      // Test 2: three failed cranks then fault.
      impuls_start();
      for (int i = 1; i <= 3; i++) begin
         sprawdz("t2_proba", 32'(proba), 32'(i));
         licz_stan(3'd1, n);
         sprawdz("t2_zaplon_len", n, 10);
         licz_stan(3'd2, n);
         sprawdz("t2_rozruch_len", n, 30);
         if (i < 3) begin
            sprawdz("t2_przerwa_outs", {29'd0, stan == 3'd3, zaplon, rozruch}, 32'b100);
            licz_stan(3'd3, n);
            sprawdz("t2_przerwa_len", n, 20);
         end
      end
      sprawdz("t2_blad_stan", 32'(stan), 32'd5);
      sprawdz("t2_blad_outs", {25'd0, blad, zaplon, rozruch, proba}, 32'b1000011);
      impuls_start();
      kroki(3);
      sprawdz("t2_blad_start_ignored", 32'(stan), 32'd5);
      stop = 1'b1;
      krok();
      stop = 1'b0;
      sprawdz("t2_stop_stan", 32'(stan), 32'd0);
      sprawdz("t2_stop_outs", {27'd0, blad, proba}, 32'd0);

      // Test 3: toggling RPM never stabilises.
      impuls_start();
      licz_stan(3'd1, n);
      n = 0;
      while (stan == 3'd2 && n < 300) begin
         obroty = (((n / 3) % 2) == 0) ? 16'd500 : 16'd0;
         krok();
         n++;
      end
      obroty = 16'd0;
      sprawdz("t3_rozruch_len", n, 30);
      sprawdz("t3_stan", 32'(stan), 32'd3);
      stop = 1'b1;
      krok();
      stop = 1'b0;

      // Test 4: stop beats run confirmation on the same edge.
      impuls_start();
      licz_stan(3'd1, n);
      kroki(4);
      obroty = 16'd500;
      kroki(3);
      sprawdz("t4_pre_stan", 32'(stan), 32'd2);
      stop = 1'b1;
      krok();
      stop = 1'b0;
      obroty = 16'd0;
      sprawdz("t4_stan", 32'(stan), 32'd0);
      sprawdz("t4_outs", {30'd0, rozruch, silnik_pracuje}, 32'd0);

      // Test 6: asynchronous reset mid-crank.
      impuls_start();
      licz_stan(3'd1, n);
      kroki(5);
      sprawdz("t6_pre_rozruch", {30'd0, rozruch, zaplon}, 32'b11);
      #3 rst = 1'b1;
      #1;
      sprawdz("t6_async_drop", {29'd0, rozruch, zaplon, stan != 3'd0}, 32'd0);
      #1 rst = 1'b0;
      krok();

      // Start held through reset release must not start.
      rst   = 1'b1;
      start = 1'b1;
      krok();
      rst = 1'b0;
      kroki(4);
      sprawdz("t6_held_start", 32'(stan), 32'd0);
      start = 1'b0;
      krok();

      // Frozen timer holds ZAPLON; restarting the clock resumes the full interval.
      taktowanie = 32'd0;
      impuls_start();
      kroki(50);
      sprawdz("t6_frozen", 32'(stan), 32'd1);
      taktowanie = 32'd10;
      licz_stan(3'd1, n);
      sprawdz("t6_resume_len", n, 10);
      stop = 1'b1;
      krok();
      stop = 1'b0;
      sprawdz("t6_end_stan", 32'(stan), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sekwenser_rozruchu.md
Name: sekwenser_rozruchu

Overview:
- Start-sequence controller that drives the starter and ignition of the engine.
- Accepts operator start/stop commands and primes the ignition.
- Cranks with a time limit, confirms run from the RPM input, and retries with cooldown up to a fixed attempt count before latching a fault.
- Sits between the operator switch logic and the starter/ignition outputs. It replaces free-running starter enables with one supervised sequence.

Parameters:
- MAX_PROB, 3: crank attempts before fault (1..15).
- CZAS_ZAPLONU_S, 1: ignition priming time before each crank, seconds.
- CZAS_ROZRUCHU_S, 5: max crank time per attempt, seconds.
- CZAS_PRZERWY_S, 10: cooldown between attempts, seconds.
- PROG_OBROTOW, 400: RPM at or above which the engine counts as running (16 bit).
- STAB_CYKLI, 100: consecutive clk cycles with obroty >= PROG_OBROTOW needed to confirm run.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- taktowanie  in  32  clk cycles per second; sampled continuously; 0 = timer frozen.
- start  in  1  start request; acted on at its rising edge only.
- stop  in  1  stop request, level; highest priority.
- obroty  in  16  measured engine RPM, unsigned.
- rozruch  out  1  starter drive.
- zaplon  out  1  ignition enable.
- silnik_pracuje  out  1  high in state PRACA.
- blad  out  1  high in state BLAD.
- proba  out  4  attempt number in progress, 1-based; 0 when idle.
- stan  out  3  state code for diagnostics.

Behaviour:
- rst: all outputs 0, state SPOCZYNEK, counters 0, start-edge register 0.
- All outputs are registered and decoded from the state register, so they change on the same edge as stan.
- Timer: prescaler counts clk up to taktowanie-1, then wraps and emits a one-cycle tick; the seconds counter counts ticks. Both clear on every state entry. An N-second state entered on edge t exits on edge t + N*taktowanie. With taktowanie = 0 no ticks occur and timed states hold.
- Start edge: start high while the previous sample was low, sampled every cycle.
- States and codes:
  - SPOCZYNEK (0): all outputs 0 and proba = 0. A start edge with stop low goes to ZAPLON with proba = 1.
  - ZAPLON (1): zaplon = 1. After CZAS_ZAPLONU_S seconds goes to ROZRUCH.
  - ROZRUCH (2): zaplon = 1, rozruch = 1. A stability counter increments on each cycle with obroty >= PROG_OBROTOW and clears on any cycle below it.
    - Counter reaching STAB_CYKLI: go to PRACA.
    - Otherwise, after CZAS_ROZRUCHU_S seconds: if proba == MAX_PROB go to BLAD, else go to PRZERWA.
    - If both fire on the same edge, PRACA wins.
  - PRZERWA (3): all drive outputs 0. After CZAS_PRZERWY_S seconds, proba increments and the state goes to ZAPLON.
  - PRACA (4): zaplon = 1, silnik_pracuje = 1, rozruch = 0, proba holds. obroty == 0 for STAB_CYKLI consecutive cycles (stall) goes to SPOCZYNEK.
  - BLAD (5): blad = 1, all drive outputs 0, proba holds. Start edges are ignored; only stop high goes to SPOCZYNEK.
- stop high in any state goes to SPOCZYNEK on the next edge and overrides every other transition in the same cycle.
- rozruch is never 1 outside ROZRUCH, and never 1 while zaplon = 0.
- A start edge outside SPOCZYNEK is ignored and does not restart the sequence.
- Start held high from reset release does not start the sequence; a fresh rising edge is required.
- Asserting rst mid-crank drops rozruch and zaplon immediately (asynchronous).
- Counters saturate and do not wrap in any state.

Test Plan:
Common setup: taktowanie = 10, CZAS_ZAPLONU_S = 1, CZAS_ROZRUCHU_S = 3, CZAS_PRZERWY_S = 2, MAX_PROB = 3, STAB_CYKLI = 4.
1. Start edge, obroty = 500 from cycle 15 after entering ROZRUCH -> rozruch high for exactly 19 cycles (15 below threshold, then 4 stable), then stan = 4, silnik_pracuje = 1, zaplon = 1, proba = 1.
2. Start edge, obroty = 0 throughout -> three 30-cycle crank windows separated by 20-cycle cooldowns, proba stepping 1, 2, 3, then blad = 1 and stan = 5. A later start edge has no effect; stop returns to stan = 0 with proba = 0.
3. In ROZRUCH, obroty toggles between 500 and 0 every 3 cycles -> the stability counter never reaches 4 and the attempt times out to PRZERWA after 30 cycles.
4. stop raised at cycle 7 of ROZRUCH, in the same cycle the stability counter hits 4 -> next edge stan = 0, rozruch = 0, silnik_pracuje = 0.
5. In PRACA, obroty = 0 for 3 cycles then 100, then 0 for 4 cycles -> stays in PRACA after the 3-cycle dip; returns to SPOCZYNEK only after the 4-cycle run of zeros.
6. rst pulse for 2 ns mid-ROZRUCH (asynchronous, between edges) -> rozruch and zaplon drop before the next clk edge. With taktowanie = 0 in ZAPLON, the state holds indefinitely.
